// File: rtl/collision_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the frogger collision/game-state block.
package collision_ctrl_pkg;

   localparam int CAR_W      = 32;
   localparam int CAR_H      = 32;
   localparam int FROG_W     = 32;
   localparam int FROG_H     = 32;
   localparam int LANE_Y1    = 320;
   localparam int LANE_Y2    = 256;
   localparam int LANE_Y3    = 192;
   localparam int LANE_Y4    = 128;
   localparam int GOAL_Y     = 32;
   localparam int LIVES_INIT = 3;
   localparam int HIT_FRAMES = 60;
   localparam int CNT_W      = 8;

   typedef enum logic [1:0] {
      ST_PLAY = 2'd0,
      ST_HIT  = 2'd1,
      ST_OVER = 2'd2
   } state_e;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/collision_ctrl_car_overlap.sv
// Combinational bounding-box overlap between the frog and one car; x wraps modulo 1024.
module car_overlap #(
   parameter int CAR_W  = collision_ctrl_pkg::CAR_W,
   parameter int CAR_H  = collision_ctrl_pkg::CAR_H,
   parameter int FROG_W = collision_ctrl_pkg::FROG_W,
   parameter int FROG_H = collision_ctrl_pkg::FROG_H
) (
   input  logic [9:0] car_x,
   input  logic [9:0] lane_y,
   input  logic [9:0] frog_x,
   input  logic [9:0] frog_y,
   output logic       hit_i
);

   localparam logic [9:0]  CAR_W_L  = 10'(CAR_W);
   localparam logic [9:0]  FROG_W_L = 10'(FROG_W);
   localparam logic [10:0] CAR_H_L  = 11'(CAR_H);
   localparam logic [10:0] FROG_H_L = 11'(FROG_H);

   logic [9:0]  dx_fc;
   logic [9:0]  dx_cf;
   logic [10:0] frog_y_w;
   logic [10:0] lane_y_w;
   logic        hx;
   logic        vy;

   // 10-bit subtraction wraps naturally, so a car straddling x=1023/0 still measures correctly.
   always_comb begin
      dx_fc    = frog_x - car_x;
      dx_cf    = car_x - frog_x;
      frog_y_w = {1'b0, frog_y};
      lane_y_w = {1'b0, lane_y};
      hx       = (dx_fc < CAR_W_L) || (dx_cf < FROG_W_L);
      vy       = (frog_y_w < lane_y_w + CAR_H_L) && (lane_y_w < frog_y_w + FROG_H_L);
      hit_i    = hx && vy;
   end

endmodule

// File: rtl/collision_ctrl.sv
// Per-frame hit/goal decision plus lives, score and PLAY/HIT/OVER game state.
module collision_ctrl #(
   parameter int CAR_W      = collision_ctrl_pkg::CAR_W,
   parameter int CAR_H      = collision_ctrl_pkg::CAR_H,
   parameter int FROG_W     = collision_ctrl_pkg::FROG_W,
   parameter int FROG_H     = collision_ctrl_pkg::FROG_H,
   parameter int LANE_Y1    = collision_ctrl_pkg::LANE_Y1,
   parameter int LANE_Y2    = collision_ctrl_pkg::LANE_Y2,
   parameter int LANE_Y3    = collision_ctrl_pkg::LANE_Y3,
   parameter int LANE_Y4    = collision_ctrl_pkg::LANE_Y4,
   parameter int GOAL_Y     = collision_ctrl_pkg::GOAL_Y,
   parameter int LIVES_INIT = collision_ctrl_pkg::LIVES_INIT,
   parameter int HIT_FRAMES = collision_ctrl_pkg::HIT_FRAMES
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       frame_tick,
   input  logic [9:0] car_x1,
   input  logic [9:0] car_x2,
   input  logic [9:0] car_x3,
   input  logic [9:0] car_x4,
   input  logic [9:0] frog_x,
   input  logic [9:0] frog_y,
   input  logic       restart,
   output logic       respawn,
   output logic       hit_flash,
   output logic [1:0] lives,
   output logic [7:0] score,
   output logic       game_over,
   output logic [1:0] state_dbg
);

   import collision_ctrl_pkg::*;

   localparam logic [1:0]       LIVES_RST = 2'(LIVES_INIT);
   localparam logic [CNT_W-1:0] HIT_LAST  = CNT_W'(HIT_FRAMES - 1);

   state_e           state_q, state_d;
   logic [1:0]       lives_q, lives_d;
   logic [7:0]       score_q, score_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             respawn_q, respawn_d;
   logic [3:0]       hit_v;
   logic             hit;
   logic             goal;

   car_overlap #(.CAR_W(CAR_W), .CAR_H(CAR_H), .FROG_W(FROG_W), .FROG_H(FROG_H)) u_car1 (
      .car_x(car_x1), .lane_y(10'(LANE_Y1)), .frog_x(frog_x), .frog_y(frog_y), .hit_i(hit_v[0]));
   car_overlap #(.CAR_W(CAR_W), .CAR_H(CAR_H), .FROG_W(FROG_W), .FROG_H(FROG_H)) u_car2 (
      .car_x(car_x2), .lane_y(10'(LANE_Y2)), .frog_x(frog_x), .frog_y(frog_y), .hit_i(hit_v[1]));
   car_overlap #(.CAR_W(CAR_W), .CAR_H(CAR_H), .FROG_W(FROG_W), .FROG_H(FROG_H)) u_car3 (
      .car_x(car_x3), .lane_y(10'(LANE_Y3)), .frog_x(frog_x), .frog_y(frog_y), .hit_i(hit_v[2]));
   car_overlap #(.CAR_W(CAR_W), .CAR_H(CAR_H), .FROG_W(FROG_W), .FROG_H(FROG_H)) u_car4 (
      .car_x(car_x4), .lane_y(10'(LANE_Y4)), .frog_x(frog_x), .frog_y(frog_y), .hit_i(hit_v[3]));

   always_comb begin
      hit  = |hit_v;
      goal = (frog_y <= 10'(GOAL_Y));
   end

   // Everything advances only on frame_tick; hit has priority over goal in PLAY.
   always_comb begin
      state_d   = state_q;
      lives_d   = lives_q;
      score_d   = score_q;
      cnt_d     = cnt_q;
      respawn_d = 1'b0;
      if (frame_tick) begin
         case (state_q)
            ST_PLAY: begin
               if (hit) begin
                  if (lives_q > 2'd1) begin
                     lives_d = lives_q - 2'd1;
                     state_d = ST_HIT;
                     cnt_d   = '0;
                  end else begin
                     lives_d = 2'd0;
                     state_d = ST_OVER;
                  end
               end else if (goal) begin
                  score_d   = sat_inc8(score_q);
                  respawn_d = 1'b1;
               end
            end
            ST_HIT: begin
               if (cnt_q == HIT_LAST) begin
                  respawn_d = 1'b1;
                  state_d   = ST_PLAY;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_OVER: begin
               if (restart) begin
                  lives_d   = LIVES_RST;
                  score_d   = 8'd0;
                  respawn_d = 1'b1;
                  state_d   = ST_PLAY;
               end
            end
            default: state_d = ST_PLAY;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= ST_PLAY;
         lives_q   <= LIVES_RST;
         score_q   <= 8'd0;
         cnt_q     <= '0;
         respawn_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         lives_q   <= lives_d;
         score_q   <= score_d;
         cnt_q     <= cnt_d;
         respawn_q <= respawn_d;
      end
   end

   always_comb begin
      respawn   = respawn_q;
      hit_flash = (state_q == ST_HIT);
      game_over = (state_q == ST_OVER);
      lives     = lives_q;
      score     = score_q;
      state_dbg = state_q;
   end

endmodule

// File: tb/tb_collision_ctrl.sv
// Directed bench for collision_ctrl: reset, hit freeze, x wrap, goal/saturation, priority, game over.
module tb_collision_ctrl;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic       frame_tick = 1'b0;
   logic [9:0] car_x1 = 10'd600, car_x2 = 10'd600, car_x3 = 10'd600, car_x4 = 10'd600;
   logic [9:0] frog_x = 10'd304, frog_y = 10'd448;
   logic       restart = 1'b0;
   logic       respawn, hit_flash, game_over;
   logic [1:0] lives, state_dbg;
   logic [7:0] score;

   int n_checks = 0;
   int n_errors = 0;

   collision_ctrl #(.LANE_Y4(0)) dut (
      .CLK(CLK), .RST_N(RST_N), .frame_tick(frame_tick),
      .car_x1(car_x1), .car_x2(car_x2), .car_x3(car_x3), .car_x4(car_x4),
      .frog_x(frog_x), .frog_y(frog_y), .restart(restart),
      .respawn(respawn), .hit_flash(hit_flash), .lives(lives), .score(score),
      .game_over(game_over), .state_dbg(state_dbg)
   );

   always #5 CLK = ~CLK;

   initial begin
      #5_000_000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge CLK);
      frame_tick = 1'b1;
      @(posedge CLK);
      #1;
      frame_tick = 1'b0;
   endtask

   task automatic idle_cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic park();
      car_x1 = 10'd600; car_x2 = 10'd600; car_x3 = 10'd600; car_x4 = 10'd600;
      frog_x = 10'd304; frog_y = 10'd448;
   endtask

   task automatic apply_reset();
      frame_tick = 1'b0;
      restart    = 1'b0;
      park();
      RST_N = 1'b0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      frog_x = 10'd100; frog_y = 10'd330; car_x1 = 10'd90;
      RST_N = 1'b0;
      tick();
      n_checks++; if (lives !== 2'd3) begin n_errors++; $display("FAIL rst_tick_lives got %0d exp %0d", lives, 3); end
      n_checks++; if (hit_flash !== 1'b0) begin n_errors++; $display("FAIL rst_tick_flash got %0b exp 0", hit_flash); end
      apply_reset();
      n_checks++; if (state_dbg !== 2'd0) begin n_errors++; $display("FAIL rst_state got %0d exp 0", state_dbg); end
      n_checks++; if (score !== 8'd0) begin n_errors++; $display("FAIL rst_score got %0d exp 0", score); end
      n_checks++; if (game_over !== 1'b0) begin n_errors++; $display("FAIL rst_over got %0b exp 0", game_over); end
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++; if (respawn !== 1'b0) begin n_errors++; $display("FAIL idle_respawn got %0b exp 0", respawn); end
      end
      n_checks++; if (lives !== 2'd3) begin n_errors++; $display("FAIL idle_lives got %0d exp 3", lives); end
      n_checks++; if (state_dbg !== 2'd0) begin n_errors++; $display("FAIL idle_state got %0d exp 0", state_dbg); end
   endtask

   task automatic test_hit_freeze();
      apply_reset();
      frog_x = 10'd100; frog_y = 10'd330; car_x1 = 10'd90;
      tick();
      n_checks++; if (hit_flash !== 1'b1) begin n_errors++; $display("FAIL hit_flash got %0b exp 1", hit_flash); end
      n_checks++; if (lives !== 2'd2) begin n_errors++; $display("FAIL hit_lives got %0d exp 2", lives); end
      n_checks++; if (state_dbg !== 2'd1) begin n_errors++; $display("FAIL hit_state got %0d exp 1", state_dbg); end
      for (int i = 1; i < 60; i++) begin
         tick();
         n_checks++; if (lives !== 2'd2 || respawn !== 1'b0 || hit_flash !== 1'b1) begin
            n_errors++; $display("FAIL freeze_%0d got lives=%0d rsp=%0b fl=%0b exp 2/0/1", i, lives, respawn, hit_flash);
         end
      end
      tick();
      n_checks++; if (respawn !== 1'b1) begin n_errors++; $display("FAIL freeze_end_respawn got %0b exp 1", respawn); end
      n_checks++; if (hit_flash !== 1'b0) begin n_errors++; $display("FAIL freeze_end_flash got %0b exp 0", hit_flash); end
      idle_cycle();
      n_checks++; if (respawn !== 1'b0) begin n_errors++; $display("FAIL freeze_pulse_width got %0b exp 0", respawn); end
   endtask

   task automatic test_wrap();
      apply_reset();
      frog_x = 10'd0; frog_y = 10'd260; car_x2 = 10'd980;
      tick();
      n_checks++; if (hit_flash !== 1'b0 || lives !== 2'd3) begin
         n_errors++; $display("FAIL wrap_980 got fl=%0b lives=%0d exp 0/3", hit_flash, lives);
      end
      car_x2 = 10'd1010;
      tick();
      n_checks++; if (hit_flash !== 1'b1 || lives !== 2'd2) begin
         n_errors++; $display("FAIL wrap_1010 got fl=%0b lives=%0d exp 1/2", hit_flash, lives);
      end
      apply_reset();
      frog_x = 10'd1000; frog_y = 10'd260; car_x2 = 10'd5;
      tick();
      n_checks++; if (hit_flash !== 1'b1 || lives !== 2'd2) begin
         n_errors++; $display("FAIL wrap_car5 got fl=%0b lives=%0d exp 1/2", hit_flash, lives);
      end
   endtask

   task automatic test_goal();
      apply_reset();
      frog_x = 10'd100; frog_y = 10'd33;
      tick();
      n_checks++; if (score !== 8'd0 || respawn !== 1'b0) begin
         n_errors++; $display("FAIL goal_y33 got score=%0d rsp=%0b exp 0/0", score, respawn);
      end
      frog_y = 10'd32;
      tick();
      n_checks++; if (score !== 8'd1 || respawn !== 1'b1) begin
         n_errors++; $display("FAIL goal_y32 got score=%0d rsp=%0b exp 1/1", score, respawn);
      end
      idle_cycle();
      n_checks++; if (respawn !== 1'b0) begin n_errors++; $display("FAIL goal_pulse_width got %0b exp 0", respawn); end
      frog_y = 10'd20;
      repeat (254) tick();
      n_checks++; if (score !== 8'd255) begin n_errors++; $display("FAIL goal_255 got %0d exp 255", score); end
      tick();
      n_checks++; if (score !== 8'd255 || respawn !== 1'b1) begin
         n_errors++; $display("FAIL goal_sat got score=%0d rsp=%0b exp 255/1", score, respawn);
      end
   endtask

   task automatic test_hit_beats_goal();
      apply_reset();
      frog_x = 10'd100; frog_y = 10'd20; car_x4 = 10'd100;
      tick();
      n_checks++; if (lives !== 2'd2 || score !== 8'd0 || respawn !== 1'b0 || hit_flash !== 1'b1) begin
         n_errors++; $display("FAIL hit_vs_goal got lives=%0d score=%0d rsp=%0b fl=%0b exp 2/0/0/1",
                              lives, score, respawn, hit_flash);
      end
   endtask

   task automatic test_game_over();
      apply_reset();
      frog_x = 10'd100; frog_y = 10'd20;
      tick();
      park();
      restart = 1'b1;
      tick();
      restart = 1'b0;
      n_checks++; if (lives !== 2'd3 || score !== 8'd1 || respawn !== 1'b0 || state_dbg !== 2'd0) begin
         n_errors++; $display("FAIL restart_in_play got lives=%0d score=%0d rsp=%0b st=%0d exp 3/1/0/0",
                              lives, score, respawn, state_dbg);
      end
      for (int k = 0; k < 2; k++) begin
         frog_x = 10'd100; frog_y = 10'd330; car_x1 = 10'd90;
         tick();
         park();
         repeat (60) tick();
      end
      n_checks++; if (lives !== 2'd1 || state_dbg !== 2'd0) begin
         n_errors++; $display("FAIL two_hits got lives=%0d st=%0d exp 1/0", lives, state_dbg);
      end
      frog_x = 10'd100; frog_y = 10'd330; car_x1 = 10'd90;
      tick();
      park();
      n_checks++; if (lives !== 2'd0 || game_over !== 1'b1 || hit_flash !== 1'b0) begin
         n_errors++; $display("FAIL last_life got lives=%0d ov=%0b fl=%0b exp 0/1/0", lives, game_over, hit_flash);
      end
      restart = 1'b1;
      repeat (3) idle_cycle();
      restart = 1'b0;
      n_checks++; if (game_over !== 1'b1 || respawn !== 1'b0) begin
         n_errors++; $display("FAIL restart_no_tick got ov=%0b rsp=%0b exp 1/0", game_over, respawn);
      end
      tick();
      n_checks++; if (game_over !== 1'b1 || lives !== 2'd0) begin
         n_errors++; $display("FAIL over_hold got ov=%0b lives=%0d exp 1/0", game_over, lives);
      end
      restart = 1'b1;
      tick();
      restart = 1'b0;
      n_checks++; if (lives !== 2'd3 || score !== 8'd0 || respawn !== 1'b1 || game_over !== 1'b0) begin
         n_errors++; $display("FAIL restart got lives=%0d score=%0d rsp=%0b ov=%0b exp 3/0/1/0",
                              lives, score, respawn, game_over);
      end
      frog_x = 10'd100; frog_y = 10'd20;
      tick();
      frog_x = 10'd100; frog_y = 10'd330; car_x1 = 10'd90;
      tick();
      repeat (10) tick();
      n_checks++; if (hit_flash !== 1'b1 || score !== 8'd1 || lives !== 2'd2) begin
         n_errors++; $display("FAIL pre_reset got fl=%0b score=%0d lives=%0d exp 1/1/2", hit_flash, score, lives);
      end
      #2;
      RST_N = 1'b0;
      #1;
      n_checks++; if (hit_flash !== 1'b0 || lives !== 2'd3 || score !== 8'd0 || respawn !== 1'b0 ||
                      game_over !== 1'b0 || state_dbg !== 2'd0) begin
         n_errors++; $display("FAIL async_reset got fl=%0b lives=%0d score=%0d rsp=%0b ov=%0b st=%0d exp 0/3/0/0/0/0",
                              hit_flash, lives, score, respawn, game_over, state_dbg);
      end
      apply_reset();
   endtask

   initial begin
      test_reset();
      test_hit_freeze();
      test_wrap();
      test_goal();
      test_hit_beats_goal();
      test_game_over();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
